// File: rtl/alu_sequencer_pkg.sv
// alu_seq_pkg: shared encodings for the multi-pass ALU sequencer.
//   op_e    : ADD / SUB / ADDX / SUBX (bit 1 = extended, bit 0 = subtract)
//   size_e  : byte / word / long / illegal
//   state_e : sequencer FSM states
//   FLAG_*  : bit positions inside the {X,N,Z,V,C} flag vector
package alu_seq_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADDX = 2'b10, OP_SUBX = 2'b11} op_e;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_WORD = 2'b01, SZ_LONG = 2'b10, SZ_ILL = 2'b11} size_e;
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
   localparam int FLAG_X = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: decoder-side request bus and write-back result bus.
//   start/op/size/src/dst/x_in/z_in : request from the decoder
//   busy/done/result/flags          : status and write-back data
//   master = decoder side, slave = sequencer side
interface alu_sequencer_if #(parameter int bits = 16);
   logic                start;
   logic [1:0]          op;
   logic [1:0]          size;
   logic [2*bits-1:0]   src;
   logic [2*bits-1:0]   dst;
   logic                x_in;
   logic                z_in;
   logic                busy;
   logic                done;
   logic [2*bits-1:0]   result;
   logic [4:0]          flags;
   modport master (output start, op, size, src, dst, x_in, z_in, input busy, done, result, flags);
   modport slave (input start, op, size, src, dst, x_in, z_in, output busy, done, result, flags);
endinterface

// File: rtl/alu_sequencer_slice.sv
// alu_slice: combinational bits-wide adder/subtractor reused by every pass.
//   i_a, i_b   : operands (subtract computes i_a - i_b)
//   i_cin      : carry-in for add, borrow-in for subtract
//   i_sub      : 1 = subtract
//   o_sum      : slice result
//   o_co_half  : carry/borrow out of bit bits/2-1, o_co_full out of bit bits-1
//   o_v_half   : signed overflow at bit bits/2-1, o_v_full at bit bits-1
module alu_slice #(parameter int bits = 16) (
   input  logic [bits-1:0] i_a,
   input  logic [bits-1:0] i_b,
   input  logic            i_cin,
   input  logic            i_sub,
   output logic [bits-1:0] o_sum,
   output logic            o_co_half,
   output logic            o_co_full,
   output logic            o_v_half,
   output logic            o_v_full
);
   localparam int h  = bits / 2;
   localparam int hw = bits - h;
   logic [bits-1:0] w_b;
   logic            w_c0;
   logic [h:0]      w_lo;
   logic [hw:0]     w_hi;
   // Subtraction is a + ~b + 1 - borrow, so the adder carry-in is the inverted borrow.
   assign w_b  = i_sub ? ~i_b : i_b;
   assign w_c0 = i_sub ? ~i_cin : i_cin;
   assign w_lo = {1'b0, i_a[h-1:0]} + {1'b0, w_b[h-1:0]} + (h+1)'(w_c0);
   assign w_hi = {1'b0, i_a[bits-1:h]} + {1'b0, w_b[bits-1:h]} + (hw+1)'(w_lo[h]);
   assign o_sum = {w_hi[hw-1:0], w_lo[h-1:0]};
   // Carry outputs are re-inverted for subtract so they can be chained straight back into i_cin.
   assign o_co_half = w_lo[h] ^ i_sub;
   assign o_co_full = w_hi[hw] ^ i_sub;
   assign o_v_half  = (i_a[h-1] == w_b[h-1]) && (o_sum[h-1] != i_a[h-1]);
   assign o_v_full  = (i_a[bits-1] == w_b[bits-1]) && (o_sum[bits-1] != i_a[bits-1]);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-pass byte/word/long ADD/SUB/ADDX/SUBX controller with 68000 flags.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : alu_sequencer_if slave (request in, busy/done/result/flags out)
module alu_sequencer
   import alu_seq_pkg::*;
#(parameter int bits = 16) (
   input logic            clk,
   input logic            reset,
   alu_sequencer_if.slave bus
);
   localparam int h = bits / 2;
   state_e              r_state, w_next;
   op_e                 r_op;
   size_e               r_size;
   logic [2*bits-1:0]   r_src, r_dst, r_result;
   logic                r_x, r_z, r_carry;
   logic [bits-1:0]     r_lo;
   logic [4:0]          r_flags;
   logic                w_accept, w_last, w_cin, w_co_half, w_co_full, w_v_half, w_v_full;
   logic                w_c, w_n, w_v, w_zero;
   logic [bits-1:0]     w_a, w_b, w_sum;
   logic [2*bits-1:0]   w_res;
   logic [4:0]          w_flags;
   assign w_accept = (r_state == IDLE || r_state == DONE) && bus.start && bus.size != SZ_ILL;
   always_comb begin
      w_next = r_state;
      w_next = w_accept ? LO :
               r_state == LO ? (r_size == SZ_LONG ? HI : DONE) :
               r_state == HI ? DONE :
               r_state == DONE ? IDLE : r_state;
   end
   // One slice serves both passes: LO works on the low halves, HI on the upper halves.
   assign w_a   = r_state == HI ? r_dst[2*bits-1:bits] : r_dst[bits-1:0];
   assign w_b   = r_state == HI ? r_src[2*bits-1:bits] : r_src[bits-1:0];
   assign w_cin = r_state == HI ? r_carry : (r_op[1] & r_x);
   alu_slice #(.bits(bits)) u_slice (
      .i_a       (w_a),
      .i_b       (w_b),
      .i_cin     (w_cin),
      .i_sub     (r_op[0]),
      .o_sum     (w_sum),
      .o_co_half (w_co_half),
      .o_co_full (w_co_full),
      .o_v_half  (w_v_half),
      .o_v_full  (w_v_full)
   );
   // Final-pass result: bits above the operand size keep the latched destination.
   always_comb begin
      w_flags = '0;
      w_last  = (r_state == LO && r_size != SZ_LONG) || r_state == HI;
      w_res   = r_state == HI ? {w_sum, r_lo} :
                r_size == SZ_BYTE ? {r_dst[2*bits-1:h], w_sum[h-1:0]} : {r_dst[2*bits-1:bits], w_sum};
      w_zero  = r_size == SZ_BYTE ? w_res[h-1:0] == '0 :
                r_size == SZ_WORD ? w_res[bits-1:0] == '0 : w_res == '0;
      w_n     = r_size == SZ_BYTE ? w_res[h-1] : r_size == SZ_WORD ? w_res[bits-1] : w_res[2*bits-1];
      w_c     = r_size == SZ_BYTE ? w_co_half : w_co_full;
      w_v     = r_size == SZ_BYTE ? w_v_half : w_v_full;
      w_flags[FLAG_X] = w_c;
      w_flags[FLAG_N] = w_n;
      w_flags[FLAG_Z] = w_zero & (~r_op[1] | r_z);
      w_flags[FLAG_V] = w_v;
      w_flags[FLAG_C] = w_c;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= OP_ADD;
         r_size   <= SZ_BYTE;
         r_src    <= '0;
         r_dst    <= '0;
         r_x      <= 1'b0;
         r_z      <= 1'b0;
         r_carry  <= 1'b0;
         r_lo     <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= op_e'(bus.op);
            r_size <= size_e'(bus.size);
            r_src  <= bus.src;
            r_dst  <= bus.dst;
            r_x    <= bus.x_in;
            r_z    <= bus.z_in;
         end
         if (r_state == LO) begin
            r_lo    <= w_sum;
            r_carry <= w_co_full;
         end
         if (w_last) begin
            r_result <= w_res;
            r_flags  <= w_flags;
         end
      end
   end
   assign bus.busy   = r_state == LO || r_state == HI;
   assign bus.done   = r_state == DONE;
   assign bus.result = r_result;
   assign bus.flags  = r_flags;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-pass controller for the 16-bit ALU slice in the v68k execution unit. It runs byte, word and long ADD/SUB/ADDX/SUBX operations. Long operands are split into two 16-bit passes, and the carry is chained between them. It also produces the 68000 condition codes X N Z V C. It sits between the instruction decoder (start/op/size handshake) and the register file write-back path.

## Interface

Parameters:

- `bits`, 16: slice width. Word = `bits`, byte = `bits/2`, long = `2*bits`.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request. Sampled only when accepting.
- `op` in 2: 00 ADD (dst+src), 01 SUB (dst−src), 10 ADDX (dst+src+X), 11 SUBX (dst−src−X).
- `size` in 2: 00 byte, 01 word, 10 long, 11 illegal.
- `src` in `2*bits`: source operand.
- `dst` in `2*bits`: destination operand.
- `x_in` in 1: current X flag. Used by ADDX/SUBX only.
- `z_in` in 1: current Z flag. Used by ADDX/SUBX only.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `result`/`flags` valid.
- `result` out `2*bits`: write-back value.
- `flags` out 5: {X,N,Z,V,C}.

## Operation

- States: IDLE, LO, HI, DONE.
- Acceptance:
  - `start` is accepted in IDLE or DONE.
  - `start` with size 11 is ignored; the state is unchanged.
  - `start` in LO/HI is ignored.
- On accept:
  - latch `op`, `size`, `src`, `dst`, `x_in`, `z_in`;
  - go to LO.
- LO:
  - compute the low slice, which is `bits` wide; a byte operation uses only its low `bits/2`.
  - carry-in = latched X for ADDX/SUBX, else 0.
  - subtraction is dst + ~src + 1 − borrow-in (borrow = inverted carry).
  - register the slice result and carry.
  - long → HI; byte/word → DONE.
- HI:
  - compute the upper slice using the registered carry from LO;
  - → DONE.
- DONE:
  - `done`=1 for exactly one cycle;
  - next state is LO if a new start is accepted, else IDLE.
- Result:
  - bits above the operand size are copied unchanged from latched `dst` (68000 partial-register semantics).
  - `result` holds its value until the next DONE.
- Flags, evaluated at operand size (bit 7 / 15 / 31):
  - C = carry out of the MSB for add, borrow for sub.
  - X = C.
  - N = result MSB.
  - V = signed overflow: operands' MSBs agree, the result MSB differs. For sub, the comparison uses the inverted src.
  - Z for ADD/SUB = sized result == 0.
  - Z for ADDX/SUBX = latched `z_in` AND (sized result == 0), i.e. sticky-clear.
- `busy` = state is LO or HI.

## Timing

- Reset: state IDLE; `busy`=0, `done`=0, `result`=0, `flags`=0.
- Reset mid-operation (LO/HI/DONE):
  - abort; IDLE on the next edge;
  - no `done` pulse;
  - `result`/`flags` cleared.
- Latency from the accepting edge E0:
  - byte/word: `done` high in the cycle after E1.
  - long: `done` high in the cycle after E2.
- Back-to-back: start accepted in DONE gives a throughput of 1 op per 2 cycles (byte/word) and 1 per 3 cycles (long).
- Inputs are sampled only at the accepting edge; later changes to `src`/`dst`/`x_in`/`z_in` have no effect on the running operation.

## Structure

- Package `alu_seq_pkg` holds:
  - op encodings (ADD/SUB/ADDX/SUBX);
  - size encodings;
  - the state enum;
  - flag bit indices: X=4, N=3, Z=2, V=1, C=0.
- Sub-module `alu_slice` (combinational):
  - inputs: `bits`-wide a/b, carry-in, subtract;
  - outputs: sum, carry out of bit `bits/2`−1 and of bit `bits`−1, overflow at both points.
- The sequencer instantiates one `alu_slice` and reuses it across passes.

## Test plan

- Word ADD, dst=ABCD7FFF, src=00000001:
  - result=ABCD8000, flags X0 N1 Z0 V1 C0;
  - `done` in the 2nd cycle after accept; `busy` high exactly 1 cycle.
- Long ADD, dst=0000FFFF, src=00000001:
  - result=00010000, flags all 0;
  - carry crosses slices; `done` in the 3rd cycle; `busy` high 2 cycles.
- Byte SUB, dst=12345600, src=00000001:
  - result=123456FF, flags X1 N1 Z0 V0 C1.
- Long SUBX, dst=00000001, src=0, x_in=1:
  - with z_in=1 → result 0, Z=1;
  - with z_in=0 → Z=0;
  - C=X=0 in both cases.
- Long ADD, FFFFFFFF+FFFFFFFF:
  - result=FFFFFFFE, X1 N1 Z0 V0 C1;
  - immediate second `start` during DONE is accepted with no idle cycle.
- Protocol and reset:
  - `start` pulsed during HI → ignored;
  - `start` with size 11 → ignored, `busy` stays 0;
  - `reset` asserted in HI → next cycle `busy`=0, `result`=0, `flags`=0, and no `done` pulse ever appears.
